// File: rtl/planificador_suma.sv
// rtl/planificador_suma.sv - round-robin scheduler sharing one AXI-Stream FP adder among N_REQ requesters
//
// Purpose:
//   Arbitrates N_REQ operand requesters onto a single AXI-Stream floating-point
//   adder (sumaDeLongitudes). A round-robin arbiter picks one requester per
//   cycle and loads a registered issue stage that drives the adder's A and B
//   channels. The winner's id is pushed into an ID FIFO, and adder results are
//   routed back combinationally to the requester at the FIFO head, in issue order.
//   No arithmetic happens here: operands and results pass through unchanged.
//
// Ports:
//   aclk, aresetn                  clock (rising edge), async active-low reset
//   req_valid/req_ready            per-requester operand handshake (ready one-hot or 0)
//   req_a, req_b                   packed operands, requester i at [32*i+31:32*i]
//   rsp_valid/rsp_ready            per-requester result handshake (valid one-hot or 0)
//   rsp_data                       shared result bus, qualified by rsp_valid
//   s_axis_a_*, s_axis_b_*         operand channels toward the adder
//   m_axis_result_*                result channel from the adder
module planificador_suma #(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 s_axis_a_tvalid,
  input  logic                 s_axis_a_tready,
  output logic [31:0]          s_axis_a_tdata,
  output logic                 s_axis_b_tvalid,
  input  logic                 s_axis_b_tready,
  output logic [31:0]          s_axis_b_tdata,
  input  logic                 m_axis_result_tvalid,
  output logic                 m_axis_result_tready,
  input  logic [31:0]          m_axis_result_tdata
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW   = ID_W + 1;
  localparam int AW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW   = $clog2(MAX_OUT + 1);

  // Issue stage
  logic             r_busy;
  logic             r_a_done;
  logic             r_b_done;
  logic [31:0]      r_a;
  logic [31:0]      r_b;

  // Round-robin pointer: search for a winner starts here
  logic [ID_W-1:0]  r_rr_ptr;

  // ID FIFO; its occupancy doubles as the in-flight count because every op
  // pushes on load and pops on its result handshake
  logic [ID_W-1:0]  r_fifo [MAX_OUT];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_a_hs;
  logic             w_b_hs;
  logic             w_op_done;
  logic             w_slot_free;
  logic             w_room;
  logic             w_found;
  logic             w_load;
  logic             w_pop;
  logic             w_ret;
  logic             w_fifo_nonempty;
  logic [ID_W-1:0]  w_winner;
  logic [ID_W-1:0]  w_ptr_next;
  logic [ID_W-1:0]  w_head_id;
  logic [ID_W-1:0]  w_cand;
  logic [SW-1:0]    w_sum;
  logic [31:0]      w_sel_a;
  logic [31:0]      w_sel_b;

  // ---------------------------------------------------------------------------
  // Adder-side handshakes. A and B may complete in different cycles; the op is
  // finished once each channel has handshaken, either earlier or right now.
  // ---------------------------------------------------------------------------
  assign s_axis_a_tvalid = r_busy & ~r_a_done;
  assign s_axis_b_tvalid = r_busy & ~r_b_done;
  assign s_axis_a_tdata  = r_a;
  assign s_axis_b_tdata  = r_b;

  assign w_a_hs    = s_axis_a_tvalid & s_axis_a_tready;
  assign w_b_hs    = s_axis_b_tvalid & s_axis_b_tready;
  assign w_op_done = r_busy & (r_a_done | w_a_hs) & (r_b_done | w_b_hs);

  // Reloading in the completing cycle gives one op per cycle when the adder
  // is always ready.
  assign w_slot_free = ~r_busy | w_op_done;
  assign w_room      = (r_count < CW'(MAX_OUT));

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first valid index at or after r_rr_ptr, modulo N_REQ.
  // The candidate sum is one bit wider so non-power-of-two N_REQ wraps cleanly.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + SW'(k);
      if (w_sum >= SW'(N_REQ)) begin
        w_sum = w_sum - SW'(N_REQ);
      end
      w_cand = w_sum[ID_W-1:0];
      if (!w_found && req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_ptr_next = (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + ID_W'(1);

  // aresetn gates the combinational accept so nothing is granted while the
  // block is held in reset, even with requesters still asserting valid.
  assign w_load = aresetn & w_slot_free & w_room & w_found;

  always_comb begin
    req_ready = '0;
    if (w_load) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_sel_a = req_a[32*i +: 32];
        w_sel_b = req_b[32*i +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Return path: zero added latency. A result with an empty FIFO has no owner,
  // so it is neither routed nor accepted.
  // ---------------------------------------------------------------------------
  assign w_fifo_nonempty = (r_count != '0);
  assign w_head_id       = r_fifo[r_rd_ptr];
  assign w_ret           = w_fifo_nonempty & m_axis_result_tvalid;

  always_comb begin
    rsp_valid = '0;
    if (w_ret) begin
      rsp_valid[w_head_id] = 1'b1;
    end
  end

  // A stalled head requester blocks every later result (head-of-line).
  assign m_axis_result_tready = w_ret & rsp_ready[w_head_id];
  assign rsp_data             = w_ret ? m_axis_result_tdata : 32'd0;
  assign w_pop                = m_axis_result_tvalid & m_axis_result_tready;

  // ---------------------------------------------------------------------------
  // Issue register and arbitration pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_busy   <= 1'b0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_load) begin
        r_busy   <= 1'b1;
        r_a_done <= 1'b0;
        r_b_done <= 1'b0;
        r_a      <= w_sel_a;
        r_b      <= w_sel_b;
        r_rr_ptr <= w_ptr_next;
      end else if (w_op_done) begin
        r_busy   <= 1'b0;
        r_a_done <= 1'b0;
        r_b_done <= 1'b0;
      end else begin
        if (w_a_hs) begin
          r_a_done <= 1'b1;
        end
        if (w_b_hs) begin
          r_b_done <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ID FIFO. Storage needs no reset: occupancy alone decides what is valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (w_load) begin
      r_fifo[r_wr_ptr] <= w_winner;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_load) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_load, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_planificador_suma.sv
// tb/tb_planificador_suma.sv - self-checking bench for planificador_suma
module tb_planificador_suma;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int PD  = 64;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  rsp_data;
  logic         s_axis_a_tvalid, s_axis_a_tready, s_axis_b_tvalid, s_axis_b_tready;
  logic [31:0]  s_axis_a_tdata, s_axis_b_tdata;
  logic         m_axis_result_tvalid, m_axis_result_tready;
  logic [31:0]  m_axis_result_tdata;

  always #5 aclk = ~aclk;

  planificador_suma #(.N_REQ(4), .MAX_OUT(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .s_axis_a_tvalid(s_axis_a_tvalid), .s_axis_a_tready(s_axis_a_tready), .s_axis_a_tdata(s_axis_a_tdata),
    .s_axis_b_tvalid(s_axis_b_tvalid), .s_axis_b_tready(s_axis_b_tready), .s_axis_b_tdata(s_axis_b_tdata),
    .m_axis_result_tvalid(m_axis_result_tvalid), .m_axis_result_tready(m_axis_result_tready),
    .m_axis_result_tdata(m_axis_result_tdata)
  );

  typedef struct packed { logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct packed { logic [1:0] id; logic [31:0] d; } sb_t;
  typedef struct packed { logic [31:0] d; int t; } res_t;
  typedef struct packed { logic [3:0] mask; logic [3:0] exp_ready; } vec_t;

  op_t         pend [N][PD];
  int          pend_rd [N];
  int          pend_wr [N];
  sb_t         sb [$];
  res_t        res_q [$];
  logic [31:0] a_q [$];
  logic [31:0] b_q [$];
  int          grants [$];
  int          grant_cyc [$];
  vec_t        vecs [10];

  logic [3:0]  rsp_rdy = 4'hF;
  logic        a_rdy = 1'b1, b_rdy = 1'b1, spurious = 1'b0, real_res = 1'b0;
  int          cyc_n = 0;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Adder stand-in: exact for doubling a normal float (exponent + 1); any other
  // pair gets a fixed stand-in combination, enough to tell results apart.
  function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b);
    if (a == b && a[30:23] != 8'd0 && a[30:23] < 8'd254) return a + 32'h0080_0000;
    return a + b;
  endfunction

  task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b);
    pend[i][pend_wr[i]] = '{a: a, b: b};
    pend_wr[i]++;
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) begin
      pend_rd[i] = 0;
      pend_wr[i] = 0;
    end
  endtask

  function automatic bit pend_busy();
    for (int i = 0; i < N; i++) if (pend_rd[i] != pend_wr[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pend_rd[i] != pend_wr[i]) begin
        req_valid[i]      = 1'b1;
        req_a[32*i +: 32] = pend[i][pend_rd[i]].a;
        req_b[32*i +: 32] = pend[i][pend_rd[i]].b;
      end else begin
        req_valid[i]      = 1'b0;
        req_a[32*i +: 32] = 32'd0;
        req_b[32*i +: 32] = 32'd0;
      end
    end
    s_axis_a_tready = a_rdy;
    s_axis_b_tready = b_rdy;
    rsp_ready       = rsp_rdy;
    real_res = (res_q.size() > 0) && (res_q[0].t <= cyc_n);
    if (real_res) begin
      m_axis_result_tvalid = 1'b1;
      m_axis_result_tdata  = res_q[0].d;
    end else if (spurious) begin
      m_axis_result_tvalid = 1'b1;
      m_axis_result_tdata  = 32'hDEAD_BEEF;
    end else begin
      m_axis_result_tvalid = 1'b0;
      m_axis_result_tdata  = 32'd0;
    end
  endtask

  task automatic cyc_begin();
    drive();
    #1;
  endtask

  // Observe what the coming rising edge will commit, update models, advance.
  task automatic cyc_end();
    logic [3:0]  g;
    logic [31:0] ar, br;
    g = req_ready & req_valid;
    chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    chk("req_ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        sb.push_back('{id: 2'(i), d: add_model(pend[i][pend_rd[i]].a, pend[i][pend_rd[i]].b)});
        pend_rd[i]++;
        grants.push_back(i);
        grant_cyc.push_back(cyc_n);
      end
    end
    if (s_axis_a_tvalid && a_rdy) a_q.push_back(s_axis_a_tdata);
    if (s_axis_b_tvalid && b_rdy) b_q.push_back(s_axis_b_tdata);
    if (real_res) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL result_owner: adder result %h with no issued request", m_axis_result_tdata);
      end else begin
        chk("rsp_valid_route", 32'(rsp_valid), 32'(4'b0001 << sb[0].id));
        chk("m_tready_follows_rsp_ready", 32'(m_axis_result_tready), 32'(rsp_rdy[sb[0].id]));
        if (m_axis_result_tready) begin
          chk("rsp_data", rsp_data, sb[0].d);
          void'(sb.pop_front());
          void'(res_q.pop_front());
        end
      end
    end else if (spurious) begin
      chk("orphan_result_tready", 32'(m_axis_result_tready), 32'd0);
      chk("orphan_result_rsp_valid", 32'(rsp_valid), 32'd0);
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    end
    if (a_q.size() > 0 && b_q.size() > 0) begin
      ar = a_q.pop_front();
      br = b_q.pop_front();
      res_q.push_back('{d: add_model(ar, br), t: cyc_n + LAT});
    end
    @(negedge aclk);
    cyc_n++;
  endtask

  task automatic cyc();
    cyc_begin();
    cyc_end();
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((sb.size() != 0 || pend_busy()) && n < max_cyc) begin
      cyc();
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Pointer starts at 1 here (test 1 grants requester 0 first).
    vecs[0] = '{mask: 4'b1111, exp_ready: 4'b0010};
    vecs[1] = '{mask: 4'b0011, exp_ready: 4'b0001};
    vecs[2] = '{mask: 4'b1000, exp_ready: 4'b1000};
    vecs[3] = '{mask: 4'b0110, exp_ready: 4'b0010};
    vecs[4] = '{mask: 4'b0100, exp_ready: 4'b0100};
    vecs[5] = '{mask: 4'b0101, exp_ready: 4'b0001};
    vecs[6] = '{mask: 4'b0000, exp_ready: 4'b0000};
    vecs[7] = '{mask: 4'b1001, exp_ready: 4'b1000};
    vecs[8] = '{mask: 4'b1110, exp_ready: 4'b0010};
    vecs[9] = '{mask: 4'b1011, exp_ready: 4'b1000};
    clear_pend();

    // Reset state with busy-looking inputs
    req_valid = 4'hF; req_a = '1; req_b = '1; rsp_ready = 4'hF;
    s_axis_a_tready = 1'b1; s_axis_b_tready = 1'b1;
    m_axis_result_tvalid = 1'b1; m_axis_result_tdata = 32'h1234_5678;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_a_tvalid", 32'(s_axis_a_tvalid), 32'd0);
    chk("rst_b_tvalid", 32'(s_axis_b_tvalid), 32'd0);
    chk("rst_a_tdata", s_axis_a_tdata, 32'd0);
    chk("rst_b_tdata", s_axis_b_tdata, 32'd0);
    chk("rst_m_tready", 32'(m_axis_result_tready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Test 1: single op, doubling
    push_op(0, 32'hC4A4_2A00, 32'hC4A4_2A00);
    cyc_begin();
    chk("t1_accept", 32'(req_ready), 32'b0001);
    chk("t1_no_tvalid_yet", 32'(s_axis_a_tvalid), 32'd0);
    cyc_end();
    cyc_begin();
    chk("t1_a_tvalid", 32'(s_axis_a_tvalid), 32'd1);
    chk("t1_b_tvalid", 32'(s_axis_b_tvalid), 32'd1);
    chk("t1_a_tdata", s_axis_a_tdata, 32'hC4A4_2A00);
    chk("t1_b_tdata", s_axis_b_tdata, 32'hC4A4_2A00);
    n = 0;
    while (!m_axis_result_tvalid && n < 10) begin
      cyc_end();
      cyc_begin();
      n++;
    end
    chk("t1_result_seen", 32'(m_axis_result_tvalid), 32'd1);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'b0001);
    chk("t1_rsp_data", rsp_data, 32'hC524_2A00);
    cyc_end();
    drain("t1_drain", 20);
    spurious = 1'b1;
    cyc_begin();
    chk("t1_fifo_empty_tready", 32'(m_axis_result_tready), 32'd0);
    cyc_end();
    spurious = 1'b0;

    // Arbitration vectors, one cycle each, unserved requesters withdraw
    for (int v = 0; v < 10; v++) begin
      clear_pend();
      for (int i = 0; i < N; i++) if (vecs[v].mask[i]) push_op(i, $urandom, $urandom);
      cyc_begin();
      chk($sformatf("vec%0d_req_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
      cyc_end();
      clear_pend();
    end
    drain("vec_drain", 50);

    // Test 2: all requesters valid, adder always ready
    clear_pend();
    grants.delete();
    grant_cyc.delete();
    for (int k = 0; k < 3; k++) for (int i = 0; i < N; i++) push_op(i, $urandom, $urandom);
    drain("t2_drain", 100);
    chk("t2_grant_count", 32'(grants.size()), 32'd12);
    if (grants.size() == 12) begin
      for (int k = 0; k < 12; k++) chk($sformatf("t2_grant%0d", k), 32'(grants[k]), 32'(k % 4));
      chk("t2_back_to_back", 32'(grant_cyc[11] - grant_cyc[0]), 32'd11);
    end

    // Test 3: A and B channels handshake in different cycles
    clear_pend();
    a_rdy = 1'b0; b_rdy = 1'b0;
    push_op(0, 32'h3F80_0000, 32'h4000_0000);
    push_op(0, 32'h4040_0000, 32'h4080_0000);
    cyc_begin();
    chk("t3_first_accept", 32'(req_ready), 32'b0001);
    cyc_end();
    cyc_begin();
    chk("t3_both_valid", 32'({s_axis_a_tvalid, s_axis_b_tvalid}), 32'b11);
    chk("t3_hold_no_accept", 32'(req_ready), 32'd0);
    cyc_end();
    a_rdy = 1'b1;
    cyc_begin();
    chk("t3_a_hs_no_accept", 32'(req_ready), 32'd0);
    cyc_end();
    a_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc_begin();
      chk($sformatf("t3_a_dropped%0d", k), 32'(s_axis_a_tvalid), 32'd0);
      chk($sformatf("t3_b_held%0d", k), 32'(s_axis_b_tvalid), 32'd1);
      chk($sformatf("t3_wait_no_accept%0d", k), 32'(req_ready), 32'd0);
      cyc_end();
    end
    b_rdy = 1'b1;
    cyc_begin();
    chk("t3_accept_on_b_hs", 32'(req_ready), 32'b0001);
    cyc_end();
    a_rdy = 1'b1;
    cyc_begin();
    chk("t3_next_a_tvalid", 32'(s_axis_a_tvalid), 32'd1);
    chk("t3_next_a_tdata", s_axis_a_tdata, 32'h4040_0000);
    cyc_end();
    drain("t3_drain", 30);

    // Test 4: results blocked, in-flight limit
    clear_pend();
    grants.delete();
    rsp_rdy = 4'h0;
    for (int k = 0; k < 5; k++) for (int i = 0; i < N; i++) push_op(i, $urandom, $urandom);
    repeat (40) cyc();
    chk("t4_accepted_max", 32'(grants.size()), 32'd16);
    cyc_begin();
    chk("t4_req_ready_blocked", 32'(req_ready), 32'd0);
    cyc_end();
    rsp_rdy = 4'hF;
    drain("t4_drain", 300);
    chk("t4_total_accepted", 32'(grants.size()), 32'd20);

    // Test 5: head-of-line block on requester 1
    clear_pend();
    rsp_rdy = 4'b1101;
    push_op(1, 32'h1111_0001, 32'h2222_0001);
    cyc();
    push_op(2, 32'h3333_0002, 32'h4444_0002);
    n = 0;
    cyc_begin();
    while (!m_axis_result_tvalid && n < 10) begin
      cyc_end();
      cyc_begin();
      n++;
    end
    chk("t5_result_seen", 32'(m_axis_result_tvalid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc_begin();
      chk($sformatf("t5_head_blocked_tready%0d", k), 32'(m_axis_result_tready), 32'd0);
      chk($sformatf("t5_only_head_valid%0d", k), 32'(rsp_valid), 32'b0010);
      cyc_end();
    end
    rsp_rdy = 4'hF;
    drain("t5_drain", 30);

    // Test 6: reset mid-stream
    clear_pend();
    for (int k = 0; k < 2; k++) for (int i = 0; i < N; i++) push_op(i, $urandom, $urandom);
    repeat (3) cyc();
    cyc_begin();
    aresetn = 1'b0;
    #1;
    chk("t6_req_ready", 32'(req_ready), 32'd0);
    chk("t6_a_tvalid", 32'(s_axis_a_tvalid), 32'd0);
    chk("t6_b_tvalid", 32'(s_axis_b_tvalid), 32'd0);
    chk("t6_a_tdata", s_axis_a_tdata, 32'd0);
    chk("t6_m_tready", 32'(m_axis_result_tready), 32'd0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rsp_data", rsp_data, 32'd0);
    sb.delete(); res_q.delete(); a_q.delete(); b_q.delete();
    clear_pend();
    @(negedge aclk);
    cyc_n++;
    drive();
    @(negedge aclk);
    cyc_n++;
    aresetn = 1'b1;
    push_op(1, $urandom, $urandom);
    push_op(3, $urandom, $urandom);
    cyc_begin();
    chk("t6_first_grant_after_reset", 32'(req_ready), 32'b0010);
    cyc_end();
    drain("t6_drain", 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
